// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter and its priority picker:
// the arbiter state encoding, default parameter values and the helpers that
// size the grant index and the burst/idle counters.
package uart_arb_pkg;

    // Arbiter state: no owner, or a grant held for a whole message.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF      = 4;
    localparam int PAYLOAD_BITS_DEF = 8;
    localparam int MAX_BURST_DEF    = 16;
    localparam int TIMEOUT_DEF      = 255;

    // Width of a requester index (NUM_REQ is at least 2, so never zero).
    function automatic int id_width(input int num_req);
        return $clog2(num_req);
    endfunction

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
// Combinational round-robin search: returns the first asserted request at
// or above ptr, wrapping past the top requester back to requester 0.
//   req   : request vector, one bit per requester
//   ptr   : requester with the highest priority this round
//   found : at least one request is asserted
//   index : winning requester (0 when nothing is found)
module rr_priority_picker
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    logic [ID_W-1:0] cand_idx;

    // Walk the requesters starting at ptr; the first hit wins and later
    // hits are ignored because found is already set.
    always_comb begin
        found    = 1'b0;
        index    = '0;
        cand_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_idx = ID_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the single UART transmit byte stream among several requesters.
// A grant is held for a whole message so bytes of different messages never
// interleave; it is cut short after MAX_BURST bytes or after the owner has
// sat idle for TIMEOUT cycles mid-message.
//   clk, resetn  : system clock, asynchronous active-low reset
//   req_valid    : per-requester byte valid
//   req_data     : requester i byte at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_last     : per-requester final-byte marker
//   req_ready    : per-requester accept (only the owner can see it high)
//   out_valid    : registered byte valid toward the UART write port
//   out_data     : registered byte
//   out_ready    : UART side can accept a byte
//   grant_id     : current or most recent owner
//   busy         : a grant is held
//   timeout_evt  : one-cycle pulse when a stalled owner loses its grant
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ      = NUM_REQ_DEF,
    parameter  int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
    parameter  int MAX_BURST    = MAX_BURST_DEF,
    parameter  int TIMEOUT      = TIMEOUT_DEF,
    localparam int ID_W         = id_width(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            out_valid,
    output logic [PAYLOAD_BITS-1:0]         out_data,
    input  logic                            out_ready,
    output logic [ID_W-1:0]                 grant_id,
    output logic                            busy,
    output logic                            timeout_evt
);

    localparam int BURST_W = cnt_width(MAX_BURST);
    localparam int IDLE_W  = cnt_width(TIMEOUT);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]    ID_MAX     = ID_W'(NUM_REQ - 1);

    arb_state_t          state;
    logic [ID_W-1:0]     ptr;
    logic [BURST_W-1:0]  burst_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic                    pick_found;
    logic [ID_W-1:0]         pick_index;
    logic                    owner_valid;
    logic                    owner_last;
    logic                    owner_ready;
    logic                    xfer;
    logic [PAYLOAD_BITS-1:0] owner_data;
    logic [ID_W-1:0]         next_ptr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .index (pick_index)
    );

    assign owner_valid = req_valid[grant_id];
    assign owner_last  = req_last[grant_id];
    assign owner_data  = req_data[int'(grant_id)*PAYLOAD_BITS +: PAYLOAD_BITS];

    // The owner may hand over a byte whenever the output register is empty
    // or is being drained this same cycle.
    assign owner_ready = (state == GRANT) && (!out_valid || out_ready);
    assign xfer        = owner_ready && owner_valid;

    // After a release, the requester just above the owner gets first pick.
    assign next_ptr = (grant_id == ID_MAX) ? '0 : grant_id + ID_W'(1);

    assign busy = (state == GRANT);

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = owner_ready;
    end

    // Grant FSM. A release (last byte, burst cap or timeout) always passes
    // through IDLE, which gives the one-cycle bubble and lets the picker see
    // the advanced ptr. The burst compare uses the pre-increment count, so
    // the owner moves exactly MAX_BURST bytes; likewise the owner is allowed
    // TIMEOUT full idle cycles before the grant is reclaimed. An owner that
    // is valid but blocked by the UART is not idle, so idle_cnt holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            grant_id    <= '0;
            ptr         <= '0;
            burst_cnt   <= '0;
            idle_cnt    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_index;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                        idle_cnt  <= '0;
                        if (owner_last || (burst_cnt == BURST_LAST)) begin
                            state <= IDLE;
                            ptr   <= next_ptr;
                        end
                    end else if (!owner_valid) begin
                        if (idle_cnt == IDLE_LAST) begin
                            state       <= IDLE;
                            ptr         <= next_ptr;
                            timeout_evt <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register, deliberately separate from the FSM so a byte taken
    // on the release edge still drains to the UART afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= owner_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
